// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write out for imem_loader
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    // Environment side: supplies the byte stream, observes the memory writes
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side: consumes the byte stream, drives the memory writes
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed bytes to big-endian imem words, CPU held in reset until loaded (optional CHECKSUM_EN)
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
`ifdef CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    // Largest legal word count: exactly fills the memory
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;
`ifdef CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  xfer;
    logic [15:0]           len_full;
    logic [31:0]           word_next;
    logic [ADDR_WIDTH:0]   widx_inc;

    assign xfer      = bus.rx_valid && rx_ready_q;
    assign len_full  = {len_hi_q, bus.rx_data};
    assign word_next = {asm_q[23:0], bus.rx_data};
    assign widx_inc  = widx_q + 1'b1;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef CHECKSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_LEN_HI;
                    len_hi_d = 8'h00;
                    len_d    = '0;
                    widx_d   = '0;
                    bcnt_d   = 2'd0;
                    asm_d    = 32'h0;
`ifdef CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_full == 16'h0000) begin
`ifdef CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        len_d   = len_full[ADDR_WIDTH:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_d  = word_next;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    // Fourth byte completes a word; the write strobe follows next cycle
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_next;
                        addr_d  = widx_q[ADDR_WIDTH-1:0];
                        widx_d  = widx_inc;
                        if (widx_inc == len_q) begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
`ifdef CHECKSUM_EN
                state_d = ST_CHECK;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered functions of the state being entered
        rx_ready_d  = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
`ifdef CHECKSUM_EN
                      (state_d == ST_CHECK) ||
`endif
                      (state_d == ST_DATA);
        busy_d      = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
`ifdef CHECKSUM_EN
                      (state_d == ST_CHECK) ||
`endif
                      (state_d == ST_DATA) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State and datapath registers; reset leaves the CPU held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= 8'h00;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= 2'd0;
            asm_q       <= 32'h0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cpu_reset, busy, done, error;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];

    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h20, 8'h09, 8'h00, 8'h0A};

    always @(negedge clk) begin
        if (reset_n && bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transfers
    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic rdy;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            rdy = bus.rx_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 40) begin
                check_eq("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !error && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("end_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Sends the two-word image, optionally with gaps, a stray start, or a bad checksum
    task automatic send_img(input bit gaps, input bit mid_start, input bit bad_sum);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 2; i < 10; i++) sum = sum ^ img[i];
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i]);
            if (gaps) idle(1);
            if (mid_start && i == 4) pulse_start();
        end
`ifdef CHECKSUM_EN
        send_byte(bad_sum ? 8'h55 : sum);
`else
        if (bad_sum) check_eq("bad_sum_unsupported", 32'd0, 32'd1);
`endif
    endtask

    task automatic check_img_writes(input string tag);
        check_eq({tag, "_nwr"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
            check_eq({tag, "_d0"}, wr_data[0], 32'h20080005);
            check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
            check_eq({tag, "_d1"}, wr_data[1], 32'h2009000A);
        end
    endtask

    task automatic check_ok(input string tag);
        check_eq({tag, "_done"},  done,      32'd1);
        check_eq({tag, "_err"},   error,     32'd0);
        check_eq({tag, "_cpurst"}, cpu_reset, 32'd0);
        check_eq({tag, "_busy"},  busy,      32'd0);
        check_eq({tag, "_rdy"},   bus.rx_ready, 32'd0);
    endtask

    initial begin
        int c;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(2);
        check_eq("rst_cpurst", cpu_reset, 32'd1);
        check_eq("rst_busy",   busy,      32'd0);
        check_eq("rst_done",   done,      32'd0);
        check_eq("rst_err",    error,     32'd0);
        check_eq("rst_rdy",    bus.rx_ready, 32'd0);
        check_eq("rst_we",     bus.imem_we,  32'd0);
        reset_n = 1'b1;
        idle(2);

        // Case 1: plain load
        pulse_start();
        check_eq("c1_busy", busy, 32'd1);
        send_img(1'b0, 1'b0, 1'b0);
        wait_end();
        check_img_writes("c1");
        check_ok("c1");

        // Case 2: gappy stream with a stray start mid-load
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        check_eq("c2_cpurst", cpu_reset, 32'd1);
        check_eq("c2_done_clr", done, 32'd0);
        send_img(1'b1, 1'b1, 1'b0);
        wait_end();
        check_img_writes("c2");
        check_ok("c2");

        // Case 3: empty image
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef CHECKSUM_EN
        send_byte(8'h00);
`endif
        c = 0;
        while (!done && c < 2) begin
            @(negedge clk);
            c++;
        end
        check_eq("c3_nwr", wr_addr.size(), 32'd0);
        check_ok("c3");

        // Case 4: oversize length
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check_eq("c4_err",    error,     32'd1);
        check_eq("c4_done",   done,      32'd0);
        check_eq("c4_cpurst", cpu_reset, 32'd1);
        check_eq("c4_rdy",    bus.rx_ready, 32'd0);
        idle(3);
        check_eq("c4_rdy_late", bus.rx_ready, 32'd0);
        check_eq("c4_nwr", wr_addr.size(), 32'd0);

`ifdef CHECKSUM_EN
        // Case 5: wrong checksum
        pulse_start();
        check_eq("c5_err_clr", error, 32'd0);
        send_img(1'b0, 1'b0, 1'b1);
        wait_end();
        check_img_writes("c5");
        check_eq("c5_err",    error,     32'd1);
        check_eq("c5_done",   done,      32'd0);
        check_eq("c5_cpurst", cpu_reset, 32'd1);
        idle(2);
`endif

        // Case 6: reset mid-load, then reload from address 0
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(img[i]);
        idle(1);
        check_eq("c6_pre_nwr", wr_addr.size(), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("c6_cpurst", cpu_reset, 32'd1);
        check_eq("c6_busy",   busy,      32'd0);
        check_eq("c6_done",   done,      32'd0);
        check_eq("c6_err",    error,     32'd0);
        check_eq("c6_rdy",    bus.rx_ready, 32'd0);
        check_eq("c6_we",     bus.imem_we,  32'd0);
        check_eq("c6_addr",   32'(bus.imem_addr), 32'd0);
        check_eq("c6_wdata",  bus.imem_wdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_img(1'b0, 1'b0, 1'b0);
        wait_end();
        check_img_writes("c6");
        check_ok("c6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
